// File: rtl/prio_det_pkg.sv
// Shared constants and helpers for the registered N-way priority detector.
// Optional mask input is enabled with PRIO_DET_MASK_EN.
package prio_det_pkg;

  localparam int PRIO_MODE_FIXED = 0;
  localparam int PRIO_MODE_RR    = 1;
  localparam int PRIO_MAX_N      = 32;

  function automatic logic [PRIO_MAX_N-1:0] onehot_from_idx(
    input logic [4:0] idx
  );
    return {{(PRIO_MAX_N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational search for the first set bit at or after a start index,
// wrapping modulo N.
module prio_find_first
  import prio_det_pkg::*;
#(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  input  logic [IDXW-1:0] start,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [N-1:0]  rot;
  logic [IDXW-1:0] pos;
  logic [IDXW:0] sum;

  always_comb begin
    rot = N'({vec, vec} >> start);
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = IDXW'(i);
    end
    found = |vec;
    // un-rotate with an explicit wrap so N need not be a power of two
    sum = {1'b0, start} + {1'b0, pos};
    if (sum >= (IDXW+1)'(N)) begin
      idx = IDXW'(sum - (IDXW+1)'(N));
    end else begin
      idx = sum[IDXW-1:0];
    end
  end

endmodule

// File: rtl/priority_detector_n.sv
// Registered N-way priority detector: fixed or round-robin winner behind a
// valid/ready slot. Define PRIO_DET_MASK_EN to add a per-channel mask input.
module priority_detector_n
  import prio_det_pkg::*;
#(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N),
  parameter int MODE = PRIO_MODE_FIXED
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
`ifdef PRIO_DET_MASK_EN
  input  logic [N-1:0]    mask,
`endif
  output logic            valid_out,
  input  logic            ready_in,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            busy_any
);

  logic [N-1:0]    eff;
  logic            found;
  logic [IDXW-1:0] win;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] ptr_nxt;
  logic [IDXW-1:0] start;
  logic [IDXW-1:0] idx_inc;
  logic            hs;
  logic            open_slot;

`ifdef PRIO_DET_MASK_EN
  assign eff = req & ~mask;
`else
  assign eff = req;
`endif

  assign hs        = valid_out & ready_in;
  assign open_slot = ~valid_out | ready_in;

  assign idx_inc = (grant_idx == IDXW'(N - 1)) ? '0
                                               : grant_idx + IDXW'(1);

  // a handshake-load searches from the pointer as advanced by that handshake
  assign ptr_nxt = (MODE == PRIO_MODE_RR && hs) ? idx_inc : ptr;
  assign start   = (MODE == PRIO_MODE_RR) ? ptr_nxt : '0;

  prio_find_first #(
    .N    (N),
    .IDXW (IDXW)
  ) u_find (
    .vec   (eff),
    .start (start),
    .found (found),
    .idx   (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      grant     <= '0;
      grant_idx <= '0;
      busy_any  <= 1'b0;
      ptr       <= '0;
    end else begin
      busy_any <= |eff;
      ptr      <= ptr_nxt;
      if (open_slot) begin
        valid_out <= found;
        grant_idx <= found ? win : '0;
        grant     <= found ? N'(onehot_from_idx(5'(win))) : '0;
      end
    end
  end

endmodule

// File: tb/tb_priority_detector_n.sv
// Randomized bench for priority_detector_n against a behavioural model,
// with directed literal sequences for fixed, round-robin, stall and reset.
module tb_priority_detector_n;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] req8  = '0;
  logic [4:0] req5  = '0;
`ifdef PRIO_DET_MASK_EN
  logic [7:0] mask8 = '0;
  logic [4:0] mask5 = '0;
`endif

  logic       v0, v1, v2, b0, b1, b2;
  logic [7:0] g0, g1;
  logic [4:0] g2;
  logic [2:0] i0, i1, i2;

  logic [7:0] eff8;
  logic [4:0] eff5;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef PRIO_DET_MASK_EN
  assign eff8 = req8 & ~mask8;
  assign eff5 = req5 & ~mask5;
`else
  assign eff8 = req8;
  assign eff5 = req5;
`endif

  priority_detector_n #(.N(8), .MODE(0)) d0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req8),
`ifdef PRIO_DET_MASK_EN
    .mask      (mask8),
`endif
    .valid_out (v0),
    .ready_in  (ready),
    .grant     (g0),
    .grant_idx (i0),
    .busy_any  (b0)
  );

  priority_detector_n #(.N(8), .MODE(1)) d1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req8),
`ifdef PRIO_DET_MASK_EN
    .mask      (mask8),
`endif
    .valid_out (v1),
    .ready_in  (ready),
    .grant     (g1),
    .grant_idx (i1),
    .busy_any  (b1)
  );

  priority_detector_n #(.N(5), .MODE(1)) d2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req5),
`ifdef PRIO_DET_MASK_EN
    .mask      (mask5),
`endif
    .valid_out (v2),
    .ready_in  (ready),
    .grant     (g2),
    .grant_idx (i2),
    .busy_any  (b2)
  );

  typedef struct {
    bit valid;
    int idx;
    int ptr;
    bit busy;
  } mst_t;

  localparam mst_t MRST = '{valid: 1'b0, idx: 0, ptr: 0, busy: 1'b0};

  mst_t m0 = MRST;
  mst_t m1 = MRST;
  mst_t m2 = MRST;

  function automatic mst_t step(mst_t s, logic [31:0] r, int n,
                                bit rr, bit rdy);
    mst_t ns;
    int   st;
    bit   hit;
    ns      = s;
    hit     = 1'b0;
    ns.busy = (r != 0);
    if (!s.valid || rdy) begin
      if (s.valid && rr) ns.ptr = (s.idx + 1) % n;
      st       = rr ? ns.ptr : 0;
      ns.valid = 1'b0;
      ns.idx   = 0;
      for (int k = 0; k < n; k++) begin
        int j;
        j = (st + k) % n;
        if (!hit && r[j]) begin
          hit      = 1'b1;
          ns.valid = 1'b1;
          ns.idx   = j;
        end
      end
    end
    return ns;
  endfunction

  function automatic logic [31:0] mgrant(mst_t s);
    return s.valid ? (32'd1 << s.idx) : 32'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= MRST;
      m1 <= MRST;
      m2 <= MRST;
    end else begin
      m0 <= step(m0, 32'(eff8), 8, 1'b0, ready);
      m1 <= step(m1, 32'(eff8), 8, 1'b1, ready);
      m2 <= step(m2, 32'(eff5), 5, 1'b1, ready);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("m0_valid", 32'(v0), 32'(m0.valid));
    chk("m0_grant", 32'(g0), mgrant(m0));
    chk("m0_idx",   32'(i0), 32'(m0.idx));
    chk("m0_busy",  32'(b0), 32'(m0.busy));
    chk("m1_valid", 32'(v1), 32'(m1.valid));
    chk("m1_grant", 32'(g1), mgrant(m1));
    chk("m1_idx",   32'(i1), 32'(m1.idx));
    chk("m1_busy",  32'(b1), 32'(m1.busy));
    chk("m2_valid", 32'(v2), 32'(m2.valid));
    chk("m2_grant", 32'(g2), mgrant(m2));
    chk("m2_idx",   32'(i2), 32'(m2.idx));
    chk("m2_busy",  32'(b2), 32'(m2.busy));
  end

  function automatic logic [7:0] rnd_req(int n);
    logic [7:0] r;
    r = 8'($urandom);
    case ($urandom % 4)
      0:       r = '0;
      1:       r = 8'd1 << ($urandom % n);
      default: r = r;
    endcase
    return r;
  endfunction

  int e1 [5] = '{0, 2, 7, 0, 2};
  int e2 [5] = '{0, 4, 0, 4, 0};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_grant", 32'(g0), 32'd0);
    chk("rst_idx",   32'(i0), 32'd0);
    chk("rst_busy",  32'(b0), 32'd0);

    rst_n = 1'b1;
    req8  = 8'b1000_0101;
    req5  = 5'b10001;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr8_valid", 32'(v1), 32'd1);
      chk("rr8_seq",   32'(i1), 32'(e1[i]));
      chk("rr5_seq",   32'(i2), 32'(e2[i]));
      chk("fx_lowest", 32'(i0), 32'd0);
    end

    req8 = 8'b0110_0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fx_valid", 32'(v0), 32'd1);
      chk("fx_grant", 32'(g0), 32'h04);
      chk("fx_idx",   32'(i0), 32'd2);
    end

    req8 = '0;
    @(negedge clk);
    chk("drain_valid", 32'(v0), 32'd0);
    req8  = 8'h08;
    ready = 1'b0;
    @(negedge clk);
    chk("stall_load", 32'(i0), 32'd3);
    req8 = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(v0), 32'd1);
      chk("stall_idx",   32'(i0), 32'd3);
      chk("stall_grant", 32'(g0), 32'h08);
      chk("stall_busy",  32'(b0), 32'd0);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("release_valid", 32'(v0), 32'd0);
    chk("release_grant", 32'(g0), 32'd0);
    chk("release_idx",   32'(i0), 32'd0);

    req8 = 8'b1000_0101;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_v0",   32'(v0), 32'd0);
    chk("arst_g0",   32'(g0), 32'd0);
    chk("arst_v1",   32'(v1), 32'd0);
    chk("arst_i1",   32'(i1), 32'd0);
    chk("arst_b1",   32'(b1), 32'd0);
    chk("arst_v2",   32'(v2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ptr_restart0", 32'(i1), 32'd0);
    @(negedge clk);
    chk("ptr_restart1", 32'(i1), 32'd2);

`ifdef PRIO_DET_MASK_EN
    req8  = 8'hFF;
    mask8 = 8'h0F;
    @(negedge clk);
    chk("mask_idx", 32'(i0), 32'd4);
    mask8 = 8'hFF;
    @(negedge clk);
    chk("mask_all_valid", 32'(v0), 32'd0);
    chk("mask_all_busy",  32'(b0), 32'd0);
    mask8 = '0;
`endif

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req8  = rnd_req(8);
      req5  = 5'(rnd_req(5));
      ready = ($urandom % 4) != 0;
`ifdef PRIO_DET_MASK_EN
      mask8 = (($urandom % 3) == 0) ? 8'($urandom) : 8'h00;
      mask5 = (($urandom % 3) == 0) ? 5'($urandom) : 5'h00;
`endif
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_detector_n.md
Name: priority_detector_n

Overview:
- Parametrised, registered successor to the 3-input combinational priority detector.
- Samples an N-bit request vector and selects one winner, using either fixed priority or round-robin.
- Presents the winner as a one-hot grant plus a binary index, behind a valid/ready output handshake.
- Sits between sensor/input-decode logic and downstream actuator or encoder stages, which may stall it.

Parameters:
- N, 8, number of request channels (2..32).
- IDXW, $clog2(N), width of grant_idx.
- MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector; bit i = channel i requesting; level-sensitive, no handshake per bit.
- valid_out  output  1  grant/grant_idx hold a valid decision.
- ready_in  input  1  downstream accepts the decision when valid_out && ready_in.
- grant  output  N  one-hot winner; all-zero when valid_out = 0.
- grant_idx  output  IDXW  binary index of the winner; 0 when valid_out = 0.
- busy_any  output  1  registered OR of the effective req vector, updated every cycle.

Behaviour:
- Reset (async assert, synchronous deassert by the clock domain):
  - valid_out = 0, grant = 0, grant_idx = 0, busy_any = 0.
  - Round-robin pointer ptr = 0.
- Output slot is a 1-entry register; its state is the valid_out flag itself.
  - EMPTY: valid_out = 0.
  - FULL: valid_out = 1.
- EMPTY, any effective req bit set at clock edge: load the winner; valid_out = 1 next cycle. Latency is 1 cycle from req to valid_out.
- EMPTY, req all zero: stay EMPTY.
- FULL && !ready_in: grant and grant_idx held stable. req changes are ignored, including withdrawal of the winning request; no retraction.
- FULL && ready_in (handshake):
  - If any effective req bit is set on that edge, load the new winner; valid_out stays 1. This gives back-to-back throughput of 1 decision per cycle.
  - Otherwise go to EMPTY.
- Winner selection:
  - MODE 0: lowest set index wins.
  - MODE 1: search starts at ptr and wraps modulo N. The first set bit at or after ptr wins.
- Pointer update (MODE 1 only):
  - Updates only on handshake: ptr = (winner_idx + 1) mod N.
  - Wrap from N-1 to 0 is explicit; N need not be a power of two.
  - The pointer never advances on a load without a handshake.
- MODE 0 ignores ptr; ptr stays 0.
- Single request: the same channel wins every cycle it requests, in both modes.
- Invariants:
  - grant is always one-hot or zero.
  - grant == (1 << grant_idx) whenever valid_out = 1.
- busy_any = |effective_req, registered; latency 1; independent of the handshake.
- Async reset mid-transfer: drops valid_out immediately and does not complete a pending handshake.

Optional Feature:
- Macro: PRIO_DET_MASK_EN.
- Defined:
  - Adds input mask, width N.
  - effective_req = req & ~mask.
  - A masked channel is never granted and does not contribute to busy_any.
  - A held grant is not revoked if its channel becomes masked while FULL.
- Undefined:
  - The mask port is absent.
  - effective_req = req.

Decomposition:
- Package prio_det_pkg:
  - Constants PRIO_MODE_FIXED = 0 and PRIO_MODE_RR = 1.
  - Function onehot_from_idx.
- Sub-module prio_find_first (combinational):
  - Inputs: vector, start index.
  - Outputs: found flag, winner index.
  - Performs the rotate / lowest-set-bit / un-rotate sequence.
  - Used with start = 0 in MODE 0 and start = ptr in MODE 1.

Test Plan:
- MODE 0, N = 8, ready_in = 1, req = 8'b0110_0100 -> next cycle valid_out = 1, grant = 8'b0000_0100, grant_idx = 2; repeats every cycle while req is held.
- MODE 1, N = 8, ready_in = 1, req = 8'b1000_0101 held -> grant_idx sequence 0, 2, 7, 0, 2, ...; ptr wraps from 7 to 0.
- MODE 1, N = 5, req = 5'b10001, ready_in = 1 -> grant_idx alternates 0, 4, 0, 4; confirms modulo-5 wrap.
- Stall: valid_out = 1 with grant_idx = 3, ready_in = 0 for 4 cycles, req changes to 0 -> grant and grant_idx stay at 3. Then ready_in = 1 -> valid_out = 0 on the next cycle.
- Reset: assert rst_n = 0 asynchronously while FULL -> valid_out, grant, grant_idx and busy_any are 0 without waiting for a clock edge. After release, MODE 1 restarts from ptr = 0.
- With PRIO_DET_MASK_EN: req = 8'hFF, mask = 8'h0F, MODE 0 -> grant_idx = 4. With mask = 8'hFF -> valid_out stays 0 and busy_any = 0.
